if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32 core.
- Directly upstream of decode; consumes the hazard unit's stall, flush_IFID and branch_taken outputs, plus trap/MRET redirects from WB.
- Owns the fetch PC and a single-outstanding request/grant/response port to instruction memory.
- Holds a one-entry skid buffer so a response arriving during a stall is not lost.

---
 rtl/if_stage.sv | 161 ++++++++++++++++
 tb/tb_if_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage and IF/ID pipeline register.
//
// Owns the fetch PC and a single-outstanding request/grant/response port to
// instruction memory. A one-entry skid buffer catches a response that cannot
// enter IF/ID in the cycle it arrives (stall or flush), so it is not lost.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   stall           hold PC and IF/ID (load-use)
//   flush_IFID      bubble IF/ID on the next edge
//   branch_taken    redirect to branch_target
//   trap_taken      redirect to trap_vector (highest priority)
//   mret_taken      redirect to mepc
//   imem_req/addr   fetch request and word-aligned address (addr = pc_F)
//   imem_gnt        request accepted this cycle
//   imem_rvalid     response for the oldest granted request
//   imem_rdata      instruction word
//   valid_ID        IF/ID holds a real instruction
//   PC_ID, inst_ID  PC and instruction word held in IF/ID
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush_IFID,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_taken,
  input  logic [31:0] trap_vector,
  input  logic        mret_taken,
  input  logic [31:0] mepc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_ID,
  output logic [31:0] PC_ID,
  output logic [31:0] inst_ID
);

  typedef enum logic [1:0] {
    IDLE,  // no outstanding request
    BUSY,  // one granted request, response pending
    DROP   // granted request pending whose response is discarded
  } state_t;

  state_t      state;
  logic [31:0] pc_F;
  logic [31:0] req_pc;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        resp_busy;
  logic        take_direct;
  logic        grant;
  logic        kill_id;

  always_comb begin
    redirect   = trap_taken | mret_taken | branch_taken;
    target_raw = branch_target;
    if (trap_taken)      target_raw = trap_vector;
    else if (mret_taken) target_raw = mepc;
    target = {target_raw[31:2], 2'b00};
  end

  // A response goes straight into IF/ID only when IF/ID will accept it this
  // edge; otherwise it is parked in the skid buffer. A plain flush_IFID kills
  // what ID holds now, not the younger word arriving, so that word is parked.
  assign resp_busy   = (state == BUSY) && imem_rvalid;
  assign take_direct = resp_busy && !redirect && !stall && !flush_IFID && !skid_valid;

  // The BUSY term lets a new request go out in the same cycle the previous
  // response is consumed, giving one instruction per cycle with 1-cycle memory.
  assign imem_req  = !rst && !skid_valid && !redirect &&
                     ((state == IDLE) || take_direct);
  assign imem_addr = pc_F;
  assign grant     = imem_req && imem_gnt;

  // Any redirect makes the instruction in ID wrong-path, so it is bubbled too;
  // this is what lets a redirect win over a simultaneous stall.
  assign kill_id = flush_IFID || redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc_F       <= RESET_PC;
      req_pc     <= RESET_PC;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= NOP_INST;
      valid_ID   <= 1'b0;
      PC_ID      <= '0;
      inst_ID    <= NOP_INST;
    end else begin
      // ---------------- fetch side ----------------
      if (redirect) begin
        pc_F       <= target;
        skid_valid <= 1'b0;
        unique case (state)
          BUSY:    state <= imem_rvalid ? IDLE : DROP;
          DROP:    if (imem_rvalid) state <= IDLE;
          default: state <= IDLE;
        endcase
      end else begin
        if (grant) begin
          req_pc <= pc_F;
          pc_F   <= pc_F + 32'd4;
        end
        unique case (state)
          IDLE: begin
            if (grant) state <= BUSY;
          end
          BUSY: begin
            if (imem_rvalid) begin
              if (!take_direct) begin
                skid_valid <= 1'b1;
                skid_pc    <= req_pc;
                skid_inst  <= imem_rdata;
              end
              state <= grant ? BUSY : IDLE;
            end
          end
          DROP: begin
            if (imem_rvalid) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
        if (skid_valid && !stall && !flush_IFID) skid_valid <= 1'b0;
      end

      // ---------------- IF/ID register ----------------
      if (kill_id) begin
        valid_ID <= 1'b0;
        inst_ID  <= NOP_INST;
      end else if (!stall) begin
        if (take_direct) begin
          valid_ID <= 1'b1;
          PC_ID    <= req_pc;
          inst_ID  <= imem_rdata;
        end else if (skid_valid) begin
          valid_ID <= 1'b1;
          PC_ID    <= skid_pc;
          inst_ID  <= skid_inst;
        end else begin
          valid_ID <= 1'b0;
          inst_ID  <= NOP_INST;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush_IFID, branch_taken, trap_taken, mret_taken;
  logic [31:0] branch_target, trap_vector, mepc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        valid_ID;
  logic [31:0] PC_ID, inst_ID;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_IFID(flush_IFID),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .trap_taken(trap_taken), .trap_vector(trap_vector),
    .mret_taken(mret_taken), .mepc(mepc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_ID(valid_ID), .PC_ID(PC_ID), .inst_ID(inst_ID)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_bad = 0;
  int unsigned n_deliv = 0;
  logic [31:0] exp_q[$];   // stream restart addresses, in issue order

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int unsigned lat_min = 1, lat_max = 1, gnt_pct = 100;
  logic        pend = 1'b0;
  int unsigned wait_cnt = 0;
  logic [31:0] pend_addr = '0;

  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (rst) begin
        pend = 1'b0;
        imem_gnt = 1'b0;
      end else begin
        if (pend) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(pend_addr);
            pend        = 1'b0;
          end
        end
        imem_gnt = ($urandom_range(99) < gnt_pct);
      end
      #4;
      if (rst) begin
        pend = 1'b0;
        check("req_low_in_rst", 32'(imem_req), 32'd0);
      end else begin
        if (trap_taken | mret_taken | branch_taken)
          check("no_req_on_redirect", 32'(imem_req), 32'd0);
        if (pend)
          check("single_outstanding", 32'(imem_req), 32'd0);
        if (imem_req && imem_gnt) begin
          check("addr_align", 32'(imem_addr[1:0]), 32'd0);
          pend      = 1'b1;
          pend_addr = imem_addr;
          wait_cnt  = $urandom_range(lat_max, lat_min);
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  // ID must see the program in order from the most recent restart address:
  // each new valid instruction is the next word after the previous one.
  logic [31:0] cur_pc = RESET_PC;
  initial begin
    logic st, r;
    forever begin
      @(posedge clk);
      st = stall;
      r  = rst;
      #1;
      while (exp_q.size() > 0) cur_pc = exp_q.pop_front();
      if (!r && !rst) begin
        if (valid_ID && !st) begin
          check("id_pc", PC_ID, cur_pc);
          check("id_inst", inst_ID, word_of(cur_pc));
          cur_pc = cur_pc + 32'd4;
          n_deliv++;
        end else if (!valid_ID) begin
          check("bubble_nop", inst_ID, NOP);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    stall = 1'b0; flush_IFID = 1'b0;
    branch_taken = 1'b0; trap_taken = 1'b0; mret_taken = 1'b0;
  endtask

  task automatic do_redirect(input logic t, input logic m, input logic b, input logic f,
                             input logic [31:0] tv, input logic [31:0] mv, input logic [31:0] bt);
    logic [31:0] tgt;
    trap_taken = t; mret_taken = m; branch_taken = b; flush_IFID = f;
    trap_vector = tv; mepc = mv; branch_target = bt;
    tgt = t ? tv : (m ? mv : bt);
    if (t | m | b) exp_q.push_back({tgt[31:2], 2'b00});
  endtask

  // Both helpers are entered and left at the pre-edge sample point.
  task automatic wait_grant(input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (imem_req && imem_gnt) begin ok = 1'b1; break; end
      @(negedge clk); #4;
    end
    if (!ok) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (valid_ID) begin ok = 1'b1; break; end
      @(negedge clk); #4;
    end
    if (!ok) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    branch_target = '0; trap_vector = '0; mepc = '0;
    repeat (3) @(negedge clk);
    #4;
    check("rst_valid", 32'(valid_ID), 32'd0);
    check("rst_pc_id", PC_ID, 32'd0);
    check("rst_inst", inst_ID, NOP);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);

    // back-to-back fetch with 1-cycle memory
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(RESET_PC);
    for (int i = 0; i < 5; i++) begin
      #4;
      check("seq_addr", imem_addr, 32'(4 * i));
      check("seq_req", 32'(imem_req), 32'd1);
      if (i >= 2) begin
        check("seq_valid", 32'(valid_ID), 32'd1);
        check("seq_pc_id", PC_ID, 32'(4 * (i - 2)));
      end else begin
        check("seq_valid_early", 32'(valid_ID), 32'd0);
      end
      @(negedge clk);
    end

    // stall while the response for 0x10 returns: it must go to the skid
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #4;
      check("skid_req_low", 32'(imem_req), 32'd0);
      check("stall_hold_pc", PC_ID, 32'h0C);
      @(negedge clk);
    end
    stall = 1'b0;
    #4;
    check("skid_full_req_low", 32'(imem_req), 32'd0);
    @(negedge clk); #4;
    check("skid_drain_valid", 32'(valid_ID), 32'd1);
    check("skid_drain_pc", PC_ID, 32'h10);
    check("skid_drain_inst", inst_ID, word_of(32'h10));
    check("after_skid_addr", imem_addr, 32'h14);
    @(negedge clk); #4;
    wait_valid(10);
    check("after_skid_pc", PC_ID, 32'h14);

    // 3-cycle memory, branch one cycle after the grant of 0x20
    lat_min = 3; lat_max = 3;
    begin
      bit found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); #4;
        if (imem_req && imem_gnt && imem_addr == 32'h20) begin found = 1'b1; break; end
      end
      check("found_grant_20", 32'(found), 32'd1);
    end
    @(negedge clk);
    do_redirect(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 32'h200);
    #4;
    check("drop_redirect_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    idle_inputs();
    #4;
    wait_grant(20);
    check("drop_next_addr", imem_addr, 32'h200);
    wait_valid(20);
    check("drop_first_pc", PC_ID, 32'h200);

    // simultaneous trap, mret and branch
    lat_min = 1; lat_max = 1;
    @(negedge clk);
    do_redirect(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 32'h40);
    #4;
    check("prio_req_low", 32'(imem_req), 32'd0);
    @(negedge clk);
    idle_inputs();
    #4;
    check("prio_addr", imem_addr, 32'h100);
    check("prio_valid", 32'(valid_ID), 32'd0);

    // stall + flush + branch together
    @(negedge clk); #4;
    wait_valid(20);
    @(negedge clk);
    do_redirect(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, 32'h300);
    stall = 1'b1;
    #4;
    @(negedge clk);
    idle_inputs();
    #4;
    check("sfb_valid", 32'(valid_ID), 32'd0);
    check("sfb_inst", inst_ID, NOP);
    check("sfb_addr", imem_addr, 32'h300);

    // PC wrap, with an unaligned target that must be masked
    @(negedge clk);
    do_redirect(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 32'hFFFF_FFFF);
    #4;
    @(negedge clk);
    idle_inputs();
    #4;
    check("wrap_target", imem_addr, 32'hFFFF_FFFC);
    wait_grant(20);
    check("wrap_grant_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #4;
    check("wrap_next_addr", imem_addr, 32'h0);

    // asynchronous reset while a request is outstanding
    lat_min = 3; lat_max = 3;
    wait_valid(20);
    wait_grant(20);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.push_back(RESET_PC);
    #1;
    check("arst_valid", 32'(valid_ID), 32'd0);
    check("arst_pc_id", PC_ID, 32'd0);
    check("arst_inst", inst_ID, NOP);
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_addr", imem_addr, RESET_PC);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat_min = 1; lat_max = 1;
    #4;
    check("arst_first_req", 32'(imem_req), 32'd1);
    check("arst_first_addr", imem_addr, RESET_PC);

    // randomized traffic
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      idle_inputs();
      if ($urandom_range(599) == 0) begin
        rst = 1'b1;
        exp_q.push_back(RESET_PC);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        stall = ($urandom_range(3) == 0);
        if ($urandom_range(99) < 6) begin
          logic t, m, b;
          logic [31:0] tv, mv, bt;
          t = ($urandom_range(2) == 0);
          m = ($urandom_range(2) == 0);
          b = ($urandom_range(1) == 0);
          if (!(t | m | b)) b = 1'b1;
          tv = $urandom; mv = $urandom; bt = $urandom;
          if ($urandom_range(3) == 0) bt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
          do_redirect(t, m, b, b & ($urandom_range(1) == 0), tv, mv, bt);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (10) @(negedge clk);
    check("deliveries_enough", 32'(n_deliv >= 300), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
